alu_rtl_design: RTL and testbench

Registered 8-bit ALU with arithmetic and logic command sets, selected by `MODE` and `CMD`. It produces a 16-bit result plus carry, overflow, compare and error flags. Operand-validity qualification comes from `INP_VALID`. It is the datapath compute block, driven by a command sequencer and observed several cycles after each command is applied.

---
 rtl/alu_rtl_design.sv | 212 +++++++++++++++++++++
 tb/tb_alu_rtl_design.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rtl_design.sv
// alu_rtl_design: registered 8-bit ALU with arithmetic and logic command sets.
// Ports:
//   CLK, RST (async active-low), CE (clock enable, outputs hold when 0)
//   MODE (1 arithmetic / 0 logic), CMD (opcode), INP_VALID ({OPB ok, OPA ok})
//   OPA, OPB (operands), CIN (carry-in)
//   RES (2N-bit result), COUT, OFLOW, G, E, L, ERR (registered flags)
// Non-multiply commands have one-cycle latency. The two multiply commands
// capture their operands on the first enabled edge and register the product
// on the second; outputs hold in between.
module alu_rtl_design #(
  parameter int N = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CE,
  input  logic           MODE,
  input  logic [3:0]     CMD,
  input  logic [1:0]     INP_VALID,
  input  logic [N-1:0]   OPA,
  input  logic [N-1:0]   OPB,
  input  logic           CIN,
  output logic [2*N-1:0] RES,
  output logic           COUT,
  output logic           OFLOW,
  output logic           G,
  output logic           E,
  output logic           L,
  output logic           ERR
);

  logic [2*N-1:0] n_res;
  logic           n_cout, n_oflow, n_g, n_e, n_l, n_err;
  logic           need_a, need_b, bad_cmd, missing, is_mul;
  logic [N-1:0]   s_sum, s_dif;
  logic [2*N-1:0] rol_dbl, ror_dbl;

  // multiply pipeline stage
  logic           pend;
  logic           stg_shift;
  logic [N-1:0]   stg_a, stg_b;
  logic [N:0]     a_inc, b_inc;
  logic [2*N-1:0] prod;

  assign s_sum   = OPA + OPB;
  assign s_dif   = OPA - OPB;
  // rotating a doubled copy lets the shifted-out bits wrap around
  assign rol_dbl = {OPA, OPA} << OPB[2:0];
  assign ror_dbl = {OPA, OPA} >> OPB[2:0];

  always_comb begin
    need_a  = 1'b0;
    need_b  = 1'b0;
    bad_cmd = 1'b0;
    if (MODE) begin
      case (CMD)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
          need_a = 1'b1;
          need_b = 1'b1;
        end
        4'd4, 4'd5: need_a = 1'b1;
        4'd6, 4'd7: need_b = 1'b1;
        default:    bad_cmd = 1'b1;
      endcase
    end else begin
      case (CMD)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: begin
          need_a = 1'b1;
          need_b = 1'b1;
        end
        4'd6, 4'd8, 4'd9:   need_a = 1'b1;
        4'd7, 4'd10, 4'd11: need_b = 1'b1;
        default:            bad_cmd = 1'b1;
      endcase
    end
    missing = (need_a & ~INP_VALID[0]) | (need_b & ~INP_VALID[1]);
  end

  always_comb begin
    n_res   = '0;
    n_cout  = 1'b0;
    n_oflow = 1'b0;
    n_g     = 1'b0;
    n_e     = 1'b0;
    n_l     = 1'b0;
    n_err   = 1'b0;
    is_mul  = 1'b0;
    if (bad_cmd || missing) begin
      n_err = 1'b1;
    end else if (MODE) begin
      case (CMD)
        4'd0: begin
          n_res  = {{(N-1){1'b0}}, ({1'b0, OPA} + {1'b0, OPB})};
          n_cout = n_res[N];
        end
        4'd1: begin
          n_res   = {{N{1'b0}}, OPA} - {{N{1'b0}}, OPB};
          n_oflow = (OPA < OPB);
        end
        4'd2: begin
          n_res  = {{(N-1){1'b0}}, ({1'b0, OPA} + {1'b0, OPB} + {{N{1'b0}}, CIN})};
          n_cout = n_res[N];
        end
        4'd3: begin
          n_res   = {{N{1'b0}}, OPA} - {{N{1'b0}}, OPB} - {{(2*N-1){1'b0}}, CIN};
          n_oflow = ({1'b0, OPA} < ({1'b0, OPB} + {{N{1'b0}}, CIN}));
        end
        4'd4: n_res = {{(N-1){1'b0}}, ({1'b0, OPA} + {{N{1'b0}}, 1'b1})};
        4'd5: n_res = {{(N-1){1'b0}}, ({1'b0, OPA} - {{N{1'b0}}, 1'b1})};
        4'd6: n_res = {{(N-1){1'b0}}, ({1'b0, OPB} + {{N{1'b0}}, 1'b1})};
        4'd7: n_res = {{(N-1){1'b0}}, ({1'b0, OPB} - {{N{1'b0}}, 1'b1})};
        4'd8: begin
          n_g = (OPA > OPB);
          n_e = (OPA == OPB);
          n_l = (OPA < OPB);
        end
        4'd9, 4'd10: is_mul = 1'b1;
        4'd11: begin
          n_res   = {{N{s_sum[N-1]}}, s_sum};
          n_oflow = (OPA[N-1] == OPB[N-1]) && (s_sum[N-1] != OPA[N-1]);
          n_g     = ($signed(OPA) > $signed(OPB));
          n_e     = (OPA == OPB);
          n_l     = ($signed(OPA) < $signed(OPB));
        end
        default: begin
          n_res   = {{N{s_dif[N-1]}}, s_dif};
          n_oflow = (OPA[N-1] != OPB[N-1]) && (s_dif[N-1] != OPA[N-1]);
          n_g     = ($signed(OPA) > $signed(OPB));
          n_e     = (OPA == OPB);
          n_l     = ($signed(OPA) < $signed(OPB));
        end
      endcase
    end else begin
      case (CMD)
        4'd0:  n_res = {{N{1'b0}}, OPA & OPB};
        4'd1:  n_res = {{N{1'b0}}, ~(OPA & OPB)};
        4'd2:  n_res = {{N{1'b0}}, OPA | OPB};
        4'd3:  n_res = {{N{1'b0}}, ~(OPA | OPB)};
        4'd4:  n_res = {{N{1'b0}}, OPA ^ OPB};
        4'd5:  n_res = {{N{1'b0}}, ~(OPA ^ OPB)};
        4'd6:  n_res = {{N{1'b0}}, ~OPA};
        4'd7:  n_res = {{N{1'b0}}, ~OPB};
        4'd8:  n_res = {{N{1'b0}}, 1'b0, OPA[N-1:1]};
        4'd9:  n_res = {{N{1'b0}}, OPA[N-2:0], 1'b0};
        4'd10: n_res = {{N{1'b0}}, 1'b0, OPB[N-1:1]};
        4'd11: n_res = {{N{1'b0}}, OPB[N-2:0], 1'b0};
        4'd12: begin
          n_res = {{N{1'b0}}, rol_dbl[2*N-1:N]};
          n_err = |OPB[N-1:4];
        end
        default: begin
          n_res = {{N{1'b0}}, ror_dbl[N-1:0]};
          n_err = |OPB[N-1:4];
        end
      endcase
    end
  end

  // second multiply stage: product of the captured operands, wrapped to 2N bits
  assign a_inc = {1'b0, stg_a} + {{N{1'b0}}, 1'b1};
  assign b_inc = {1'b0, stg_b} + {{N{1'b0}}, 1'b1};

  always_comb begin
    if (stg_shift)
      prod = {{N{1'b0}}, stg_a[N-2:0], 1'b0} * {{N{1'b0}}, stg_b};
    else
      prod = {{(N-1){1'b0}}, a_inc} * {{(N-1){1'b0}}, b_inc};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES       <= '0;
      COUT      <= 1'b0;
      OFLOW     <= 1'b0;
      G         <= 1'b0;
      E         <= 1'b0;
      L         <= 1'b0;
      ERR       <= 1'b0;
      pend      <= 1'b0;
      stg_shift <= 1'b0;
      stg_a     <= '0;
      stg_b     <= '0;
    end else if (CE) begin
      if (is_mul) begin
        // a held multiply recaptures every edge; the product lands once a
        // capture from the previous edge is pending
        stg_a     <= OPA;
        stg_b     <= OPB;
        stg_shift <= (CMD == 4'd10);
        pend      <= 1'b1;
        if (pend) begin
          RES   <= prod;
          COUT  <= 1'b0;
          OFLOW <= 1'b0;
          G     <= 1'b0;
          E     <= 1'b0;
          L     <= 1'b0;
          ERR   <= 1'b0;
        end
      end else begin
        pend  <= 1'b0;
        RES   <= n_res;
        COUT  <= n_cout;
        OFLOW <= n_oflow;
        G     <= n_g;
        E     <= n_e;
        L     <= n_l;
        ERR   <= n_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_rtl_design.sv
// Scoreboard bench for alu_rtl_design: the driver pushes the reference
// model's expectation when it issues a command; the monitor pops and compares
// when the command's sample point arrives.
module tb_alu_rtl_design;

  logic        clk = 1'b0;
  logic        rst_n, ce, mode, cin;
  logic [3:0]  cmd;
  logic [1:0]  iv;
  logic [7:0]  opa, opb;
  logic [15:0] res;
  logic        cout, oflow, g, e, l, err;
  logic [21:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;

  exp_t        sb_q[$];
  logic [21:0] last_exp = '0;
  event        sample_ev;

  // operand needs per opcode: bit0 = OPA, bit1 = OPB, 0 = unused code
  localparam int ARITH_NEED[16] = '{3,3,3,3,1,1,2,2,3,3,3,3,3,0,0,0};
  localparam int LOGIC_NEED[16] = '{3,3,3,3,3,3,1,2,1,1,2,2,3,3,0,0};

  always #5 clk = ~clk;

  alu_rtl_design #(.N(8)) dut (
    .CLK(clk), .RST(rst_n), .CE(ce), .MODE(mode), .CMD(cmd),
    .INP_VALID(iv), .OPA(opa), .OPB(opb), .CIN(cin),
    .RES(res), .COUT(cout), .OFLOW(oflow), .G(g), .E(e), .L(l), .ERR(err)
  );

  assign obs = {res, cout, oflow, g, e, l, err};

  function automatic logic [21:0] model(input bit m, input int c, input int v,
                                        input int a, input int b, input int ci);
    int r = 0;
    int sa, sb, t, sh, need;
    bit fc = 0, fo = 0, fg = 0, fe = 0, fl = 0, fe_err = 0;
    sa   = (a >= 128) ? a - 256 : a;
    sb   = (b >= 128) ? b - 256 : b;
    need = m ? ARITH_NEED[c] : LOGIC_NEED[c];
    if (need == 0 || (need & ~v) != 0) begin
      fe_err = 1;
    end else if (m) begin
      case (c)
        0: begin r = a + b; fc = (r >= 256); end
        1: begin r = (a - b) & 65535; fo = (a < b); end
        2: begin r = a + b + ci; fc = (r >= 256); end
        3: begin r = (a - b - ci) & 65535; fo = (a < b + ci); end
        4: r = a + 1;
        5: r = (a - 1) & 511;
        6: r = b + 1;
        7: r = (b - 1) & 511;
        8: begin fg = (a > b); fe = (a == b); fl = (a < b); end
        9: r = ((a + 1) * (b + 1)) & 65535;
        10: r = ((a * 2) & 255) * b;
        default: begin
          t  = (c == 11) ? sa + sb : sa - sb;
          r  = t & 255;
          if (r >= 128) r = r | 16'hFF00;
          fo = (t > 127) || (t < -128);
          fg = (sa > sb); fe = (sa == sb); fl = (sa < sb);
        end
      endcase
    end else begin
      sh = b % 8;
      case (c)
        0: r = a & b;
        1: r = ~(a & b) & 255;
        2: r = a | b;
        3: r = ~(a | b) & 255;
        4: r = a ^ b;
        5: r = ~(a ^ b) & 255;
        6: r = ~a & 255;
        7: r = ~b & 255;
        8: r = a >> 1;
        9: r = (a << 1) & 255;
        10: r = b >> 1;
        11: r = (b << 1) & 255;
        12: begin r = ((a << sh) | (a >> (8 - sh))) & 255; fe_err = (b > 15); end
        default: begin r = ((a >> sh) | (a << (8 - sh))) & 255; fe_err = (b > 15); end
      endcase
    end
    return {16'(r), fc, fo, fg, fe, fl, fe_err};
  endfunction

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got res=%h c=%b o=%b gel=%b%b%b err=%b, want res=%h c=%b o=%b gel=%b%b%b err=%b",
                  tag, got[21:6], got[5], got[4], got[3], got[2], got[1], got[0],
                  want[21:6], want[5], want[4], want[3], want[2], want[1], want[0]);
  endtask

  // monitor: compare whenever a command's outputs are due
  initial begin
    exp_t x;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        chk("sb_underflow", obs, 22'h3FFFFF);
      end else begin
        x = sb_q.pop_front();
        chk(x.tag, obs, x.v);
      end
    end
  end

  task automatic issue(input bit m, input int c, input int v, input int a,
                       input int b, input int ci, input bit en, input string tag);
    exp_t x;
    @(negedge clk);
    mode = m; cmd = 4'(c); iv = 2'(v); opa = 8'(a); opb = 8'(b); cin = ci[0]; ce = en;
    x.tag = tag;
    x.v   = en ? model(m, c, v, a, b, ci) : last_exp;
    last_exp = x.v;
    sb_q.push_back(x);
    repeat (4) @(posedge clk);
    @(negedge clk);
    -> sample_ev;
  endtask

  task automatic set_in(input bit m, input int c, input int a, input int b);
    mode = m; cmd = 4'(c); iv = 2'b11; opa = 8'(a); opb = 8'(b); cin = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit m, en;
    int c, v;
    rst_n = 1'b0; ce = 1'b1;
    set_in(1, 0, 8'hFF, 8'h01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", obs, '0);
    rst_n = 1'b1; ce = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rel_ce0", obs, '0);

    issue(1, 0,  3, 8'hFF, 8'h01, 0, 1, "add_ff_01");
    issue(1, 2,  3, 8'h10, 8'h20, 1, 1, "addcin");
    issue(1, 1,  3, 8'h05, 8'h0A, 0, 1, "sub_under");
    issue(1, 8,  3, 8'h3C, 8'h3C, 0, 1, "cmp_eq");
    issue(1, 9,  3, 8'h02, 8'h03, 0, 1, "mul9");
    issue(1, 10, 3, 8'h81, 8'h02, 0, 1, "mul10");
    issue(1, 11, 3, 8'h7F, 8'h01, 0, 1, "sadd_ovf");
    issue(0, 4,  3, 8'hF0, 8'hAA, 0, 1, "xor");
    issue(0, 12, 3, 8'h81, 8'h01, 0, 1, "rol");
    issue(0, 13, 3, 8'h01, 8'h11, 0, 1, "ror_err");
    issue(1, 0,  1, 8'h12, 8'h34, 0, 1, "missing_b");
    issue(0, 15, 3, 8'h12, 8'h34, 0, 1, "bad_cmd");
    issue(1, 0,  3, 8'h55, 8'h66, 0, 0, "ce0_hold");
    issue(1, 13, 3, 8'h01, 8'h01, 0, 1, "arith_unused");
    issue(1, 5,  3, 8'h00, 8'h00, 0, 1, "dec_a_zero");

    // multiply latency and CE freeze
    issue(1, 0, 3, 1, 1, 0, 1, "add_pre_mul");
    @(negedge clk); set_in(1, 9, 4, 5); ce = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mul_hold", obs, last_exp);
    ce = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mul_freeze", obs, last_exp);
    ce = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mul_resume", obs, model(1, 9, 3, 4, 5, 0));
    last_exp = model(1, 9, 3, 4, 5, 0);
    set_in(1, 10, 3, 7);
    @(posedge clk); @(negedge clk);
    chk("mul10_hold", obs, last_exp);
    @(posedge clk); @(negedge clk);
    chk("mul10_lat2", obs, model(1, 10, 3, 3, 7, 0));

    // reset in the middle of a multiply
    set_in(1, 9, 9, 9);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_async", obs, '0);
    @(negedge clk);
    rst_n = 1'b1; set_in(1, 9, 16, 16);
    @(posedge clk); @(negedge clk);
    chk("rst_discard", obs, '0);
    @(posedge clk); @(negedge clk);
    chk("post_rst_mul", obs, model(1, 9, 3, 16, 16, 0));
    last_exp = model(1, 9, 3, 16, 16, 0);

    for (int i = 0; i < 250; i++) begin
      m  = 1'($urandom_range(0, 1));
      c  = $urandom_range(0, 15);
      v  = $urandom_range(0, 7);
      if (v > 3) v = 3;
      en = ($urandom_range(0, 7) != 0);
      issue(m, c, v, $urandom_range(0, 255),
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 15),
            $urandom_range(0, 1), en, $sformatf("rnd%0d_m%0d_c%0d_v%0d_ce%0d", i, m, c, v, en));
    end

    @(negedge clk);
    chk("sb_drain", 22'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
